// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: IDLE grants, ACCESS drives memory, RESP returns data.
// Optional macro DMEM_ARB_RR_EN selects round-robin tie-breaking; otherwise m0 has fixed priority.
module dmem_arbiter #(
    parameter int DEPTH_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    output logic [1:0]  dbg_state_o
);
    // Handshake: req is held until a one-cycle gnt; the matching rvalid pulse follows exactly two cycles later.
    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    state_e      state_q, state_d;
    logic        cmd_we_q, cmd_port_q;
    logic [31:0] cmd_addr_q, cmd_wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        grant0, grant1, in_range, idle;

    assign idle     = rst_n && (state_q == IDLE);
    assign in_range = {2'b00, cmd_addr_q[31:2]} < DEPTH_L;

`ifdef DMEM_ARB_RR_EN
    logic last_q;  // 1: m1 was granted most recently, so m0 wins the next tie

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (idle) begin
            if (m0_req && m1_req) begin
                grant0 = last_q;
                grant1 = !last_q;
            end else begin
                grant0 = m0_req;
                grant1 = m1_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (grant0 || grant1) begin
            last_q <= grant1;
        end
    end
`else
    always_comb begin
        grant0 = idle && m0_req;
        grant1 = idle && m1_req && !m0_req;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (m0_req || m1_req) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cmd_we_q    <= 1'b0;
            cmd_port_q  <= 1'b0;
            cmd_addr_q  <= 32'd0;
            cmd_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant0 || grant1) begin
                cmd_port_q  <= grant1;
                cmd_we_q    <= grant1 ? m1_we    : m0_we;
                cmd_addr_q  <= grant1 ? m1_addr  : m0_addr;
                cmd_wdata_q <= grant1 ? m1_wdata : m0_wdata;
            end
            // Response is frozen at the end of ACCESS so RESP does not depend on mem_rd.
            if (state_q == ACCESS) begin
                err_q   <= !in_range;
                rdata_q <= (in_range && !cmd_we_q) ? mem_rd : 32'd0;
            end
        end
    end

    always_comb begin
        m0_gnt      = grant0;
        m1_gnt      = grant1;
        m0_rvalid   = rst_n && (state_q == RESP) && !cmd_port_q;
        m1_rvalid   = rst_n && (state_q == RESP) && cmd_port_q;
        m0_rdata    = m0_rvalid ? rdata_q : 32'd0;
        m1_rdata    = m1_rvalid ? rdata_q : 32'd0;
        m0_err      = m0_rvalid && err_q;
        m1_err      = m1_rvalid && err_q;
        mem_we      = rst_n && (state_q == ACCESS) && cmd_we_q && in_range;
        mem_a       = cmd_addr_q;
        mem_wd      = cmd_wdata_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter with an attached memory, a transaction-level reference model and a response scoreboard.
module tb_dmem_arbiter;
    localparam int DEPTH = 64;
    localparam int W     = 66;  // {due_cycle[31:0], port, err, rdata[31:0]}

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err, mem_we;
    logic [31:0] m0_rdata, m1_rdata, mem_a, mem_wd, mem_rd;
    logic [1:0]  dbg_state;

    int unsigned vectors = 0, miscompares = 0, cyc = 0;
    logic        mem_loaded = 1'b0;
    logic [31:0] phys    [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    logic [W-1:0] exp_q[$];

    dmem_arbiter #(.DEPTH_WORDS(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] seed_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    // ---------------- attached memory ----------------
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < DEPTH; i++) phys[i] <= seed_word(i);
        end else if (mem_we && (mem_a[31:2] < DEPTH)) begin
            phys[mem_a[7:2]] <= mem_wd;
        end
    end
    assign mem_rd = (mem_a[31:2] < DEPTH) ? phys[mem_a[7:2]] : 32'd0;

    // ---------------- reference model ----------------
    int          busy = 0;
    logic        last = 1'b1;
    logic        c_port, c_we;
    logic [31:0] c_addr, c_wdata;

    always @(negedge clk) begin
        logic w0, w1, inr;
        logic [31:0] rd;
        if (!mem_loaded) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = seed_word(i);
        end
        if (!rst_n) begin
            busy = 0;
            last = 1'b1;
            exp_q.delete();
            vectors++;
            if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_we} != 7'd0 ||
                m0_rdata != 0 || m1_rdata != 0) begin
                miscompares++;
                $display("FAIL reset_outputs cyc=%0d gnt=%b%b rvalid=%b%b err=%b%b mem_we=%b want all 0",
                         cyc, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_we);
            end
        end else if (busy == 0) begin
`ifdef DMEM_ARB_RR_EN
            if (m0_req && m1_req) begin w0 = last; w1 = !last; end
            else begin w0 = m0_req; w1 = m1_req; end
`else
            w0 = m0_req;
            w1 = m1_req && !m0_req;
`endif
            vectors++;
            if (m0_gnt !== w0 || m1_gnt !== w1 || mem_we !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_grant cyc=%0d got gnt=%b%b mem_we=%b want gnt=%b%b mem_we=0",
                         cyc, m0_gnt, m1_gnt, mem_we, w0, w1);
            end
            if (w0 || w1) begin
                c_port  = w1;
                c_we    = w1 ? m1_we    : m0_we;
                c_addr  = w1 ? m1_addr  : m0_addr;
                c_wdata = w1 ? m1_wdata : m0_wdata;
                last    = w1;
                busy    = 2;
            end
        end else begin
            vectors++;
            if (m0_gnt || m1_gnt) begin
                miscompares++;
                $display("FAIL busy_grant cyc=%0d got gnt=%b%b want 00", cyc, m0_gnt, m1_gnt);
            end
            if (busy == 2) begin
                inr = c_addr[31:2] < DEPTH;
                vectors++;
                if (mem_we !== (c_we && inr) || mem_a !== c_addr || (c_we && inr && mem_wd !== c_wdata)) begin
                    miscompares++;
                    $display("FAIL access cyc=%0d got we=%b a=%h wd=%h want we=%b a=%h wd=%h",
                             cyc, mem_we, mem_a, mem_wd, c_we && inr, c_addr, c_wdata);
                end
                rd = (inr && !c_we) ? ref_mem[c_addr[7:2]] : 32'd0;
                if (inr && c_we) ref_mem[c_addr[7:2]] = c_wdata;
                exp_q.push_back({cyc + 32'd1, c_port, !inr, rd});
            end else if (mem_we) begin
                vectors++;
                miscompares++;
                $display("FAIL resp_mem_we cyc=%0d got mem_we=1 want 0", cyc);
            end
            busy--;
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e, a;
        if (rst_n) begin
            if (m0_rvalid || m1_rvalid) begin
                vectors++;
                a = {cyc, m1_rvalid, m1_rvalid ? m1_err : m0_err, m1_rvalid ? m1_rdata : m0_rdata};
                if (m0_rvalid && m1_rvalid) begin
                    miscompares++;
                    $display("FAIL dual_rvalid cyc=%0d got both rvalid want one", cyc);
                end else if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL spurious_rvalid cyc=%0d got rvalid port=%0d want none", cyc, m1_rvalid);
                end else begin
                    e = exp_q.pop_front();
                    if (a !== e) begin
                        miscompares++;
                        $display("FAIL response got cyc=%0d port=%0d err=%b rdata=%h want cyc=%0d port=%0d err=%b rdata=%h",
                                 a[65:34], a[33], a[32], a[31:0], e[65:34], e[33], e[32], e[31:0]);
                    end
                end
            end else if (exp_q.size() != 0 && exp_q[0][65:34] <= cyc) begin
                e = exp_q.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missing_rvalid cyc=%0d got none want port=%0d at cyc=%0d", cyc, e[33], e[65:34]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_port(input bit p, input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata);
        if (p) begin m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; end
        else   begin m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; end
    endtask

    // Called just after a rising edge; returns just after the edge that follows the grant.
    task automatic issue(input bit p, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        bit got = 0;
        set_port(p, 1'b1, we, addr, wdata);
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            got = p ? m1_gnt : m0_gnt;
        end
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL grant_timeout port=%0d got no gnt want gnt within 200 cycles", p);
        end
        @(posedge clk);
        #1;
        set_port(p, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'($urandom_range(DEPTH, 2 * DEPTH - 1)) << 2;
            1:       return $urandom;
            default: return (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
        endcase
    endfunction

    task automatic random_port(input bit p, input int n);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            issue(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit got;
        repeat (3) @(posedge clk);
        #1;
        mem_loaded = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        repeat (2) @(posedge clk);
        #1;
        issue(1, 1'b0, 32'h10, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        issue(0, 1'b1, 32'h100, 32'h1234_5678);
        repeat (2) @(posedge clk);
        #1;

        // Both requesters held high: tie-breaking is exercised on every idle slot.
        set_port(0, 1'b1, 1'b0, 32'h10, 32'd0);
        set_port(1, 1'b1, 1'b0, 32'h14, 32'd0);
        repeat (12) @(posedge clk);
        #1;
        set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (4) @(posedge clk);
        #1;

        fork
            random_port(0, 40);
            random_port(1, 40);
        join
        repeat (5) @(posedge clk);
        #1;

        // Reset in the ACCESS cycle of a write must squash it.
        issue(0, 1'b1, 32'h20, 32'hA5A5_5A5A);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (mem_we !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_mem_we got %b want 0", mem_we);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        vectors++;
        if (phys[8] !== ref_mem[8]) begin
            miscompares++;
            $display("FAIL abort_mem_word got %h want %h", phys[8], ref_mem[8]);
        end
        set_port(0, 1'b1, 1'b0, 32'h20, 32'd0);
        set_port(1, 1'b1, 1'b0, 32'h24, 32'd0);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = m0_gnt || m1_gnt;
        end
        vectors++;
        if (!(m0_gnt && !m1_gnt)) begin
            miscompares++;
            $display("FAIL post_reset_winner got gnt=%b%b want 10", m0_gnt, m1_gnt);
        end
        @(posedge clk);
        #1;
        set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
        set_port(1, 1'b0, 1'b0, 32'd0, 32'd0);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
